// File: rtl/spi_read_ctrl_pkg.sv
// Shared types and helpers for the SPI read sequencer: FSM state encoding,
// press counter width, and the counter-width helper.
package spi_read_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int PRESS_CNT_W = 8;

    // Width of a counter that must hold values 0..x-1, never narrower than 1 bit.
    function automatic int cnt_w(input int x);
        int w;
        w = $clog2(x);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_read_ctrl_if.sv
// Start/done handshake between the read sequencer (master) and the SPI read engine (slave).
interface spi_read_if #(
    parameter int DATA_W = 16
);
    // spi_start_o is a single-cycle request; the slave answers later with a
    // single-cycle spi_done_i, and spi_data_i is meaningful only in that cycle.
    logic              spi_start_o;
    logic              spi_done_i;
    logic [DATA_W-1:0] spi_data_i;

    modport master (output spi_start_o, input spi_done_i, input spi_data_i);
    modport slave  (input spi_start_o, output spi_done_i, output spi_data_i);
endinterface

// File: rtl/spi_read_ctrl_rise_det.sv
// Rising-edge detector on the debounced switch level. The history register
// resets high so a level already high when reset releases is not a press.
module rise_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic db_i,
    output logic press_o
);
    logic r_db_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_db_q <= 1'b1;
        end else begin
            r_db_q <= db_i;
        end
    end

    assign press_o = db_i & ~r_db_q;
endmodule

// File: rtl/spi_read_ctrl.sv
// Burst read sequencer: each switch press issues N_READS SPI reads, spaced by
// GAP_CYC idle cycles, each guarded by a TIMEOUT_CYC wait limit.
module spi_read_ctrl
    import spi_read_pkg::*;
#(
    parameter  int DATA_W      = 16,
    parameter  int N_READS     = 4,
    parameter  int GAP_CYC     = 8,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int IDX_W       = cnt_w(N_READS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   db_i,
    spi_read_if.master             spi,
    output logic [DATA_W-1:0]      data_o,
    output logic                   data_valid_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   busy_o,
    output logic                   burst_done_o,
    output logic                   timeout_o,
    output logic [PRESS_CNT_W-1:0] press_cnt_o,
    output state_t                 state_o
);
    localparam int GAP_W = cnt_w(GAP_CYC);
    localparam int TO_W  = cnt_w(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] RD_LAST  = IDX_W'(N_READS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_press;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_capture;
    logic                   w_last;
    logic                   w_to_hit;

    logic [IDX_W-1:0]       r_rd_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [TO_W-1:0]        r_to_cnt;
    logic [DATA_W-1:0]      r_data;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_data_valid;
    logic                   r_burst_done;
    logic                   r_timeout;
    logic [PRESS_CNT_W-1:0] r_press_cnt;

    rise_det u_rise_det (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .db_i    (db_i),
        .press_o (w_press)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A done in the same cycle the timeout counter expires is treated as done.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        w_to_hit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_accept    = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_start     = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (spi.spi_done_i) begin
                    w_capture = 1'b1;
                    if (r_rd_cnt == RD_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = (GAP_CYC == 0) ? START : GAP;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_to_hit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = START;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_to_cnt     <= '0;
            r_data       <= '0;
            r_idx        <= '0;
            r_data_valid <= 1'b0;
            r_burst_done <= 1'b0;
            r_timeout    <= 1'b0;
            r_press_cnt  <= '0;
        end else begin
            r_data_valid <= w_capture;
            r_burst_done <= w_last;
            if (w_capture) begin
                r_data <= spi.spi_data_i;
                r_idx  <= r_rd_cnt;
            end
            if (w_accept) begin
                r_press_cnt <= r_press_cnt + 1'b1;
                r_timeout   <= 1'b0;
                r_rd_cnt    <= '0;
            end else if (w_capture && !w_last) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
            // The gap counter idles at zero so every GAP entry starts a fresh count.
            if (r_state == START) begin
                r_to_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign spi.spi_start_o = w_start;
    assign data_o          = r_data;
    assign data_valid_o    = r_data_valid;
    assign idx_o           = r_idx;
    assign busy_o          = (r_state != IDLE);
    assign burst_done_o    = r_burst_done;
    assign timeout_o       = r_timeout;
    assign press_cnt_o     = r_press_cnt;
    assign state_o         = r_state;
endmodule

// File: tb/tb_spi_read_ctrl.sv
// Directed bench for spi_read_ctrl: SPI responder model, word scoreboard,
// and a linear sequence of press / burst / timeout / reset scenarios.
module tb_spi_read_ctrl;
    import spi_read_pkg::*;

    localparam int DATA_W      = 16;
    localparam int N_READS     = 4;
    localparam int GAP_CYC     = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int IDX_W       = cnt_w(N_READS);
    localparam int W           = DATA_W + IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic db_man = 1'b0;
    logic db_auto = 1'b0;
    logic db;
    logic mdl_done = 1'b0;
    logic [DATA_W-1:0] mdl_data = '0;
    logic man_done = 1'b0;
    logic [DATA_W-1:0] man_data = '0;

    logic [DATA_W-1:0] data_o;
    logic              data_valid_o;
    logic [IDX_W-1:0]  idx_o;
    logic              busy_o;
    logic              burst_done_o;
    logic              timeout_o;
    logic [7:0]        press_cnt_o;
    state_t            state_o;

    spi_read_if #(.DATA_W(DATA_W)) bus ();

    assign db             = db_man | db_auto;
    assign bus.spi_done_i = mdl_done | man_done;
    assign bus.spi_data_i = man_done ? man_data : mdl_data;

    spi_read_ctrl #(
        .DATA_W(DATA_W), .N_READS(N_READS), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .db_i(db), .spi(bus.master),
        .data_o(data_o), .data_valid_o(data_valid_o), .idx_o(idx_o), .busy_o(busy_o),
        .burst_done_o(burst_done_o), .timeout_o(timeout_o), .press_cnt_o(press_cnt_o),
        .state_o(state_o)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard and monitor state
    logic [W-1:0] exp_q[$];
    int start_cyc[$];
    int dv_cyc[$];
    int start_n = 0, dv_n = 0, bd_n = 0;
    int bd_cyc = -1, busy_fall_cyc = -1, to_rise_cyc = -1;
    logic prev_busy = 1'b0, prev_to = 1'b0;
    logic model_en = 1'b0, auto_en = 1'b0;
    int cd = 0, m_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_mon();
        exp_q.delete();
        start_cyc.delete();
        dv_cyc.delete();
        start_n = 0; dv_n = 0; bd_n = 0;
        bd_cyc = -1; busy_fall_cyc = -1; to_rise_cyc = -1;
    endtask

    task automatic push_burst();
        for (int i = 0; i < N_READS; i++) begin
            exp_q.push_back({IDX_W'(i), 16'hA5A0 + 16'(i)});
        end
    endtask

    task automatic wait_bd(input int target, input int budget);
        int k = 0;
        while (bd_n < target && k < budget) begin
            tick(1);
            k++;
        end
        chk("burst_done_wait", 32'(bd_n >= target), 32'd1);
    endtask

    // SPI responder, auto re-press driver and output monitor, all on the falling edge
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mdl_done = 1'b1;
                mdl_data = 16'hA5A0 + 16'(m_idx);
                m_idx    = (m_idx + 1) % N_READS;
            end
        end
        if (model_en && bus.spi_start_o) cd = 3;
        db_auto = auto_en && burst_done_o && (bd_n < 255);
        if (bus.spi_start_o) begin
            start_n++;
            start_cyc.push_back(cyc);
        end
        if (data_valid_o) begin
            dv_n++;
            dv_cyc.push_back(cyc);
            chk("word_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("word", 32'({idx_o, data_o}), 32'(exp_q.pop_front()));
        end
        if (burst_done_o) begin
            bd_n++;
            bd_cyc = cyc;
        end
        if (prev_busy && !busy_o) busy_fall_cyc = cyc;
        if (timeout_o && !prev_to) to_rise_cyc = cyc;
        prev_busy = busy_o;
        prev_to   = timeout_o;
    end

    initial begin
        int t0;
        // reset with the switch already high
        rst = 1'b1; db_man = 1'b1;
        tick(3);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_valid", 32'(data_valid_o), 32'h0);
        chk("rst_idx", 32'(idx_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_burst_done", 32'(burst_done_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        chk("rst_press_cnt", 32'(press_cnt_o), 32'h0);
        chk("rst_start", 32'(bus.spi_start_o), 32'h0);
        clear_mon();
        rst = 1'b0;
        tick(20);
        chk("held_no_start", 32'(start_n), 32'd0);
        chk("held_press_cnt", 32'(press_cnt_o), 32'd0);

        // one full burst
        model_en = 1'b1; m_idx = 0;
        db_man = 1'b0;
        tick(1);
        clear_mon();
        push_burst();
        db_man = 1'b1;
        t0 = cyc + 1;
        wait_bd(1, 200);
        tick(2);
        chk("b1_starts", 32'(start_n), 32'd4);
        chk("b1_words", 32'(dv_n), 32'd4);
        chk("b1_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("b1_press_cnt", 32'(press_cnt_o), 32'd1);
        chk("b1_busy", 32'(busy_o), 32'd0);
        if (start_cyc.size() == 4 && dv_cyc.size() == 4) begin
            chk("b1_first_start", 32'(start_cyc[0]), 32'(t0));
            chk("b1_first_word", 32'(dv_cyc[0]), 32'(t0 + 4));
            for (int i = 1; i < 4; i++) chk("b1_gap", 32'(start_cyc[i] - dv_cyc[i-1]), 32'd8);
            chk("b1_done_with_last", 32'(bd_cyc), 32'(dv_cyc[3]));
        end

        // re-press during a burst is dropped
        db_man = 1'b0;
        tick(1);
        clear_mon();
        push_burst();
        db_man = 1'b1;
        tick(9);
        chk("b2_busy_mid", 32'(busy_o), 32'd1);
        db_man = 1'b0;
        tick(2);
        db_man = 1'b1;
        wait_bd(1, 200);
        tick(40);
        chk("b2_press_cnt", 32'(press_cnt_o), 32'd2);
        chk("b2_words", 32'(dv_n), 32'd4);
        chk("b2_starts", 32'(start_n), 32'd4);
        chk("b2_busy", 32'(busy_o), 32'd0);

        // no answer from SPI: timeout
        model_en = 1'b0;
        db_man = 1'b0;
        tick(1);
        clear_mon();
        db_man = 1'b1;
        t0 = 0;
        while (busy_fall_cyc < 0 && t0 < 60) begin
            tick(1);
            t0++;
        end
        chk("to_starts", 32'(start_n), 32'd1);
        chk("to_words", 32'(dv_n), 32'd0);
        chk("to_flag", 32'(timeout_o), 32'd1);
        if (start_cyc.size() == 1) begin
            chk("to_busy_fall", 32'(busy_fall_cyc), 32'(start_cyc[0] + 17));
            chk("to_flag_rise", 32'(to_rise_cyc), 32'(start_cyc[0] + 17));
        end
        model_en = 1'b1; m_idx = 0;
        db_man = 1'b0;
        tick(1);
        clear_mon();
        push_burst();
        db_man = 1'b1;
        tick(1);
        chk("to_cleared", 32'(timeout_o), 32'd0);
        chk("to_press_cnt", 32'(press_cnt_o), 32'd4);
        wait_bd(1, 200);

        // reset while waiting for done, then a late done
        model_en = 1'b0;
        db_man = 1'b0;
        tick(1);
        clear_mon();
        db_man = 1'b1;
        tick(2);
        chk("rw_in_wait", 32'(state_o), 32'(WAIT));
        chk("rw_press_cnt", 32'(press_cnt_o), 32'd5);
        rst = 1'b1;
        clear_mon();
        tick(1);
        rst = 1'b0;
        man_done = 1'b1; man_data = 16'h1234;
        tick(1);
        man_done = 1'b0;
        tick(10);
        chk("rw_starts", 32'(start_n), 32'd0);
        chk("rw_words", 32'(dv_n), 32'd0);
        chk("rw_data", 32'(data_o), 32'h0);
        chk("rw_idx", 32'(idx_o), 32'h0);
        chk("rw_busy", 32'(busy_o), 32'd0);
        chk("rw_press_cnt0", 32'(press_cnt_o), 32'd0);
        chk("rw_state", 32'(state_o), 32'(IDLE));

        // 256 back-to-back bursts, each re-pressed in the burst_done cycle
        model_en = 1'b1; m_idx = 0;
        db_man = 1'b0;
        tick(1);
        clear_mon();
        for (int b = 0; b < 256; b++) push_burst();
        db_man = 1'b1;
        tick(1);
        db_man = 1'b0;
        auto_en = 1'b1;
        wait_bd(256, 20000);
        tick(60);
        auto_en = 1'b0;
        chk("bb_bursts", 32'(bd_n), 32'd256);
        chk("bb_words", 32'(dv_n), 32'd1024);
        chk("bb_starts", 32'(start_n), 32'd1024);
        chk("bb_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("bb_press_wrap", 32'(press_cnt_o), 32'd0);
        chk("bb_busy", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_read_ctrl.md
# spi_read_ctrl

Sequencer between the switch debouncer and the SPI read master in the SPI read IP. Each accepted rising edge of the debounced switch level starts a burst of N_READS SPI read transactions. Bursts are spaced by a programmable gap and guarded by a per-transaction timeout. Each returned word is presented on a registered output with a one-cycle valid strobe.

## Interface
- DATA_W, 16, SPI read word width
- N_READS, 4, reads per burst (≥1)
- GAP_CYC, 8, idle cycles between a word's capture and the next start (≥0)
- TIMEOUT_CYC, 1024, max cycles waiting for spi_done_i (≥2)
- clk_i  in  1  system clock; all logic is on the rising edge
- rst_i  in  1  synchronous, active-high reset
- db_i  in  1  debounced switch level from the debouncer
- spi_start_o  out  1  one-cycle start pulse to the SPI master
- spi_done_i  in  1  one-cycle completion pulse from the SPI master
- spi_data_i  in  DATA_W  read word; valid when spi_done_i=1
- data_o  out  DATA_W  captured word, held until the next capture
- data_valid_o  out  1  one-cycle strobe; data_o is new
- idx_o  out  $clog2(N_READS) (min 1)  index of the word in data_o within its burst
- busy_o  out  1  burst in progress (state≠IDLE)
- burst_done_o  out  1  one-cycle pulse when the last word of a burst is captured
- timeout_o  out  1  sticky flag; last burst aborted on timeout
- press_cnt_o  out  8  count of accepted presses, wraps 255→0

## Operation
- Edge detector: db_q is db_i registered, and db_q resets to 1. A press is db_i=1 with db_q=0. A level held high through reset release is not a press.
- States: IDLE, START, WAIT, GAP.
- IDLE: on a press, go to START. press_cnt_o increments, timeout_o clears, and the read counter rd_cnt is set to 0.
- START: spi_start_o=1 for exactly this cycle. Clear the timeout counter and go to WAIT.
- WAIT, spi_done_i=1: capture spi_data_i into data_o and rd_cnt into idx_o, and pulse data_valid_o next cycle.
  - If rd_cnt=N_READS-1, pulse burst_done_o and go to IDLE.
  - Otherwise increment rd_cnt and go to GAP, or to START if GAP_CYC=0.
- WAIT, no done: increment the timeout counter. When it reaches TIMEOUT_CYC-1, go to IDLE and set timeout_o. No data_valid_o.
- GAP: count GAP_CYC cycles, then go to START.
- Presses while busy_o=1 are dropped, not queued. db_q still tracks db_i, so the held level never becomes a later press.
- spi_done_i outside WAIT is ignored.
- Reset values: spi_start_o=0, data_o=0, data_valid_o=0, idx_o=0, busy_o=0, burst_done_o=0, timeout_o=0, press_cnt_o=0, state=IDLE.

## Timing
- Press sampled at edge E → spi_start_o high in cycle E+1; busy_o high from E+1.
- spi_done_i sampled at edge F → data_valid_o and the new data_o/idx_o in cycle F+1.
- Next spi_start_o comes GAP_CYC cycles after the data_valid_o cycle. With GAP_CYC=0 it is the same cycle.
- Last word: data_valid_o, burst_done_o and busy_o=0 all occur in cycle F+1. A press sampled at edge F+1 is accepted.
- Timeout: if no done is sampled in the TIMEOUT_CYC cycles after the start cycle, busy_o=0 and timeout_o=1 in the following cycle.
- spi_done_i at the timeout edge counts as done; done wins.
- Reset mid-burst: all outputs take reset values on the next edge and no further start is issued. A late spi_done_i is ignored.

## Structure
- Package spi_read_pkg holds:
  - the state enum type (IDLE, START, WAIT, GAP)
  - the PRESS_CNT_W=8 constant
  - a counter-width helper function (max($clog2(x),1)) used for the rd_cnt, gap and timeout counters.
- One sub-module: rise_det. It registers db_i into db_q (reset value 1) and outputs the one-cycle press pulse.
- Everything else is the FSM plus three counters in spi_read_ctrl.

## Test plan
- Reset with db_i=1, then release reset and hold db_i=1 for 20 cycles → no spi_start_o, press_cnt_o=0.
- One press, SPI model answers 3 cycles after each start with 0xA5A0+idx (N_READS=4, GAP_CYC=8):
  - 4 starts, each 8 cycles after the previous data_valid_o
  - data_o = 0xA5A0..0xA5A3 with idx_o = 0..3
  - burst_done_o with the last word; press_cnt_o=1.
- Re-press during a burst → ignored. press_cnt_o unchanged, exactly 4 words, no extra burst after busy_o falls.
- SPI model never answers (TIMEOUT_CYC=16) → single start, timeout_o=1 and busy_o=0 exactly 17 cycles after the start cycle. The next press clears timeout_o.
- rst_i asserted for 1 cycle while in WAIT, then spi_done_i pulsed → spi_start_o=0 and no data_valid_o; outputs at reset values.
- 256 bursts back-to-back, each press sampled in the burst_done_o cycle → all accepted, press_cnt_o wraps to 0.
